// File: rtl/divided_mod_m_counter.sv
// Tick-driven modulo counter: a free-running divide-by-DIV_M strobe enables
// a modulo-CNT_M counter, giving a slow time base on a single clock domain.
module divided_mod_m_counter #(
    parameter int DIV_M = 12,
    parameter int DIV_N = 4,
    parameter int CNT_M = 100,
    parameter int CNT_N = 8
) (
    input  logic             clk,
    input  logic             reset,
    output logic             max_tick,
    output logic [CNT_N-1:0] r
);

    localparam logic [DIV_N-1:0] DIV_LAST = DIV_N'(DIV_M - 1);
    localparam logic [CNT_N-1:0] CNT_LAST = CNT_N'(CNT_M - 1);

    generate
        if (((2 ** DIV_N) < DIV_M) || ((2 ** CNT_N) < CNT_M)) begin : g_bad_width
            $error("divided_mod_m_counter: register width too small for modulus");
        end
    endgenerate

    logic [DIV_N-1:0] r_q;
    logic [CNT_N-1:0] r_count;
    logic             w_tick;

    // Tick is decoded straight from the divider state, so it has no extra latency.
    assign w_tick   = (r_q == DIV_LAST);
    assign max_tick = w_tick;
    assign r        = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (w_tick) begin
            r_q <= '0;
        end else begin
            r_q <= r_q + DIV_N'(1);
        end
    end

    // Counter advances only on tick edges; out-of-range values still step by one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_tick) begin
            if (r_count == CNT_LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_N'(1);
            end
        end
    end

endmodule

// File: tb/tb_divided_mod_m_counter.sv
// Bench for divided_mod_m_counter: an edge-count model predicts both outputs
// for the default build and a DIV_M=1, CNT_M=3 build under random resets.
`timescale 1ns/100ps
module tb_divided_mod_m_counter;

    localparam int D1 = 12;
    localparam int C1 = 100;
    localparam int D2 = 1;
    localparam int C2 = 3;

    logic       clk;
    logic       reset;
    logic       clkRun;
    logic       tick1;
    logic [7:0] r1;
    logic       tick2;
    logic [1:0] r2;

    int total;
    int bad;
    int k;

    divided_mod_m_counter #(.DIV_M(D1), .DIV_N(4), .CNT_M(C1), .CNT_N(8)) dut1 (
        .clk(clk), .reset(reset), .max_tick(tick1), .r(r1)
    );

    divided_mod_m_counter #(.DIV_M(D2), .DIV_N(1), .CNT_M(C2), .CNT_N(2)) dut2 (
        .clk(clk), .reset(reset), .max_tick(tick2), .r(r2)
    );

    initial begin
        clk = 1'b0;
        wait (clkRun);
        forever #1 clk = ~clk;
    end

    // Model: k counts rising edges since the last reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) k <= 0;
        else       k <= k + 1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d (k=%0d, t=%0t)", name, actual, expected, k, $time);
        end
    endtask

    // Compare process: every falling edge, both builds against the arithmetic model.
    always @(negedge clk) begin
        checkOutput("cmpTick1", int'(tick1), int'((k % D1) == D1 - 1));
        checkOutput("cmpR1",    int'(r1),    (k / D1) % C1);
        checkOutput("cmpTick2", int'(tick2), int'((k % D2) == D2 - 1));
        checkOutput("cmpR2",    int'(r2),    (k / D2) % C2);
    end

    // Holds reset across two rising edges, then releases just after a falling edge.
    task automatic applyStimulus();
        @(negedge clk);
        #0.3 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #0.3 reset = 1'b0;
    endtask

    task automatic runEdges(input int n);
        repeat (n) @(posedge clk);
        #0.5;
    endtask

    initial begin
        int ticks;
        int lastTick;
        total  = 0;
        bad    = 0;
        clkRun = 1'b0;
        reset  = 1'b0;

        #0.5 reset = 1'b1;
        #0.2;
        checkOutput("asyncResetR", int'(r1), 0);
        checkOutput("asyncResetTick", int'(tick1), 0);
        clkRun = 1'b1;

        applyStimulus();
        runEdges(11);
        checkOutput("edge11Tick", int'(tick1), 1);
        checkOutput("edge11R", int'(r1), 0);
        runEdges(1);
        checkOutput("edge12Tick", int'(tick1), 0);
        checkOutput("edge12R", int'(r1), 1);

        applyStimulus();
        runEdges(1199);
        checkOutput("edge1199R", int'(r1), 99);
        checkOutput("edge1199Tick", int'(tick1), 1);
        runEdges(1);
        checkOutput("wrapR", int'(r1), 0);

        applyStimulus();
        ticks    = 0;
        lastTick = -1;
        for (int i = 0; i < 1250; i++) begin
            if (tick1) begin
                ticks++;
                if (lastTick >= 0) checkOutput("tickSpacing", i - lastTick, 12);
                lastTick = i;
            end
            runEdges(1);
        end
        checkOutput("tickCount", ticks, 104);
        checkOutput("edge1250R", int'(r1), 4);
        checkOutput("edge1250Tick", int'(tick1), 0);
        runEdges(9);
        checkOutput("q2ToTick", int'(tick1), 1);

        applyStimulus();
        runEdges(449);
        checkOutput("midCountR", int'(r1), 37);
        reset = 1'b1;
        #0.1;
        checkOutput("midResetR", int'(r1), 0);
        checkOutput("midResetTick", int'(tick1), 0);
        #0.2 reset = 1'b0;
        runEdges(10);
        checkOutput("postResetNoTick", int'(tick1), 0);
        runEdges(1);
        checkOutput("postResetTick", int'(tick1), 1);

        applyStimulus();
        checkOutput("div1ResetTick", int'(tick2), 1);
        checkOutput("div1ResetR", int'(r2), 0);
        runEdges(1);
        checkOutput("div1R1", int'(r2), 1);
        runEdges(1);
        checkOutput("div1R2", int'(r2), 2);
        runEdges(1);
        checkOutput("div1R0", int'(r2), 0);
        checkOutput("div1Tick", int'(tick2), 1);

        for (int n = 0; n < 25; n++) begin
            runEdges($urandom_range(1, 400));
            @(negedge clk);
            #($urandom_range(1, 8) * 0.1) reset = 1'b1;
            #0.05;
            checkOutput("randResetR", int'(r1), 0);
            checkOutput("randResetTick", int'(tick1), 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            @(negedge clk);
            #($urandom_range(1, 8) * 0.1) reset = 1'b0;
        end
        runEdges(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
